// File: rtl/mig_port_pkg.sv
// Shared definitions for the MIG user-port emulator: opcodes, executor states, FIFO depth.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mig_port_pkg;

    // Depth of the write-data and read-data FIFOs, as seen on a real MIG user port.
    localparam int FIFO_DEPTH = 64;

    // Cycles spent in REFRESH before returning to IDLE.
    localparam int REFRESH_CYCLES = 8;

    localparam logic [2:0] OP_WRITE    = 3'b000;
    localparam logic [2:0] OP_WRITE_AP = 3'b010;
    localparam logic [2:0] OP_READ     = 3'b001;
    localparam logic [2:0] OP_READ_AP  = 3'b011;
    localparam logic [2:0] OP_REFRESH  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_WAIT,
        S_READ,
        S_REFRESH
    } state_e;

    // State the executor enters after popping a command. Unknown opcodes map
    // to IDLE, so they are consumed in the single IDLE cycle that popped them.
    function automatic state_e op_to_state(input logic [2:0] op);
        case (op)
            OP_WRITE, OP_WRITE_AP: op_to_state = S_WRITE;
            OP_READ, OP_READ_AP:   op_to_state = S_RD_WAIT;
            OP_REFRESH:            op_to_state = S_REFRESH;
            default:               op_to_state = S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mig_port_emu_sync_fifo.sv
// Generic first-word-fall-through FIFO; dout_o shows the head whenever empty_o=0, and 0 when empty.
// Latency: a pushed word is visible at dout_o the cycle after the push edge.
// Backpressure: push while full is dropped (even with a same-cycle pop); pop while empty is ignored.
// Ports: clk_i/rst_ni (sync active-low), push_i/din_i, pop_i/dout_o, full_o/empty_o/count_o (registered occupancy).
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 64,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Flags come from the registered count, so a full FIFO rejects a push
    // even if the head is popped in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mig_port_emu.sv
// Behavioural emulation of a Spartan-6 MIG user port (cmd/wr/rd FIFOs) over a 2^MEM_AW x 32 memory.
// Latency: read burst data reaches the read FIFO RD_LATENCY+1 cycles after the command is popped.
// Backpressure: none upstream; full FIFOs drop pushes and raise sticky error/overflow flags.
// Ports: mig_cmd_* command push/status, mig_wr_* write data FIFO, mig_rd_* read data FIFO; *_clk inputs unused.
module mig_port_emu
    import mig_port_pkg::*;
#(
    parameter int MEM_AW     = 10,
    parameter int RD_LATENCY = 4,
    parameter int CMD_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mig_cmd_clk,
    input  logic        mig_wr_clk,
    input  logic        mig_rd_clk,
    input  logic        mig_cmd_en,
    input  logic [2:0]  mig_cmd_instr,
    input  logic [5:0]  mig_cmd_bl,
    input  logic [29:0] mig_cmd_byte_addr,
    output logic        mig_cmd_empty,
    output logic        mig_cmd_full,
    input  logic        mig_wr_en,
    input  logic [3:0]  mig_wr_mask,
    input  logic [31:0] mig_wr_data,
    output logic        mig_wr_full,
    output logic        mig_wr_empty,
    output logic [6:0]  mig_wr_count,
    output logic        mig_wr_underrun,
    output logic        mig_wr_error,
    input  logic        mig_rd_en,
    output logic [31:0] mig_rd_data,
    output logic        mig_rd_full,
    output logic        mig_rd_empty,
    output logic [6:0]  mig_rd_count,
    output logic        mig_rd_overflow,
    output logic        mig_rd_error
);
    localparam int CMD_W  = 3 + 6 + MEM_AW;
    localparam int CMD_CW = $clog2(CMD_DEPTH + 1);
    localparam logic [7:0] RD_WAIT_LOAD = 8'(RD_LATENCY - 1);
    localparam logic [7:0] REF_LOAD     = 8'(REFRESH_CYCLES - 1);

    logic [CMD_W-1:0]  cmd_din;
    logic [CMD_W-1:0]  cmd_dout;
    logic [CMD_CW-1:0] cmd_count;
    logic              cmd_pop;
    logic [2:0]        cmd_op;
    logic [5:0]        cmd_bl;
    logic [MEM_AW-1:0] cmd_idx;
    state_e            cmd_state;
    logic [35:0]       wr_dout;
    logic              wr_pop;
    logic              rd_push;
    logic [31:0]       rd_din;

    logic [31:0]       mem_q [2**MEM_AW];
    logic              mem_we;
    logic [31:0]       wr_word;
    logic [3:0]        wr_mask;

    state_e            state_q;
    logic [MEM_AW-1:0] addr_q;
    logic [5:0]        beats_q;
    logic [7:0]        wait_q;
    logic              wr_underrun_q;
    logic              wr_error_q;
    logic              rd_overflow_q;
    logic              rd_error_q;

    // Only the word index is queued; byte-offset and high address bits alias away.
    assign cmd_din   = {mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr[MEM_AW+1:2]};
    assign cmd_op    = cmd_dout[CMD_W-1 -: 3];
    assign cmd_bl    = cmd_dout[MEM_AW +: 6];
    assign cmd_idx   = cmd_dout[MEM_AW-1:0];
    assign cmd_state = op_to_state(cmd_op);

    assign cmd_pop = (state_q == S_IDLE) && !mig_cmd_empty;
    assign wr_pop  = (state_q == S_WRITE);
    assign rd_push = (state_q == S_READ);
    assign rd_din  = mem_q[addr_q];

    // An empty write FIFO at a needed beat writes zero to all bytes.
    assign wr_word = mig_wr_empty ? 32'h0 : wr_dout[31:0];
    assign wr_mask = mig_wr_empty ? 4'h0  : wr_dout[35:32];
    // Gated by reset so an aborted burst never lands a word in the reset cycle.
    assign mem_we  = rst_n && (state_q == S_WRITE);

    assign mig_wr_underrun = wr_underrun_q;
    assign mig_wr_error    = wr_error_q;
    assign mig_rd_overflow = rd_overflow_q;
    assign mig_rd_error    = rd_error_q;

    logic unused_ok;
    assign unused_ok = ^{mig_cmd_clk, mig_wr_clk, mig_rd_clk, mig_cmd_byte_addr, cmd_count};

    sync_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (mig_cmd_en),
        .din_i   (cmd_din),
        .pop_i   (cmd_pop),
        .dout_o  (cmd_dout),
        .full_o  (mig_cmd_full),
        .empty_o (mig_cmd_empty),
        .count_o (cmd_count)
    );

    sync_fifo #(.W(36), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (mig_wr_en),
        .din_i   ({mig_wr_mask, mig_wr_data}),
        .pop_i   (wr_pop),
        .dout_o  (wr_dout),
        .full_o  (mig_wr_full),
        .empty_o (mig_wr_empty),
        .count_o (mig_wr_count)
    );

    sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (rd_push),
        .din_i   (rd_din),
        .pop_i   (mig_rd_en),
        .dout_o  (mig_rd_data),
        .full_o  (mig_rd_full),
        .empty_o (mig_rd_empty),
        .count_o (mig_rd_count)
    );

    // Backing store: synchronous byte-masked write, combinational read. A read
    // command always follows its preceding write by at least one cycle, so the
    // read sees the updated word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!wr_mask[b]) mem_q[addr_q][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            beats_q       <= '0;
            wait_q        <= '0;
            wr_underrun_q <= 1'b0;
            wr_error_q    <= 1'b0;
            rd_overflow_q <= 1'b0;
            rd_error_q    <= 1'b0;
        end else begin
            if (mig_wr_en && mig_wr_full)  wr_error_q <= 1'b1;
            if (mig_rd_en && mig_rd_empty) rd_error_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (!mig_cmd_empty) begin
                        addr_q  <= cmd_idx;
                        beats_q <= cmd_bl;
                        wait_q  <= (cmd_state == S_REFRESH) ? REF_LOAD : RD_WAIT_LOAD;
                        if (cmd_state == S_RD_WAIT && RD_LATENCY == 0) state_q <= S_READ;
                        else                                           state_q <= cmd_state;
                    end
                end
                S_WRITE: begin
                    if (mig_wr_empty) wr_underrun_q <= 1'b1;
                    addr_q <= addr_q + MEM_AW'(1);   // wraps modulo 2^MEM_AW
                    if (beats_q == '0) state_q <= S_IDLE;
                    else               beats_q <= beats_q - 6'd1;
                end
                S_RD_WAIT: begin
                    if (wait_q == '0) state_q <= S_READ;
                    else              wait_q  <= wait_q - 8'd1;
                end
                S_READ: begin
                    if (mig_rd_full) rd_overflow_q <= 1'b1;
                    addr_q <= addr_q + MEM_AW'(1);
                    if (beats_q == '0) state_q <= S_IDLE;
                    else               beats_q <= beats_q - 6'd1;
                end
                S_REFRESH: begin
                    if (wait_q == '0) state_q <= S_IDLE;
                    else              wait_q  <= wait_q - 8'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mig_port_emu.sv
module tb_mig_port_emu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mig_cmd_en;
    logic [2:0]  mig_cmd_instr;
    logic [5:0]  mig_cmd_bl;
    logic [29:0] mig_cmd_byte_addr;
    logic        mig_cmd_empty, mig_cmd_full;
    logic        mig_wr_en;
    logic [3:0]  mig_wr_mask;
    logic [31:0] mig_wr_data;
    logic        mig_wr_full, mig_wr_empty;
    logic [6:0]  mig_wr_count;
    logic        mig_wr_underrun, mig_wr_error;
    logic        mig_rd_en;
    logic [31:0] mig_rd_data;
    logic        mig_rd_full, mig_rd_empty;
    logic [6:0]  mig_rd_count;
    logic        mig_rd_overflow, mig_rd_error;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mig_port_emu #(.MEM_AW(10), .RD_LATENCY(4), .CMD_DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mig_cmd_clk       (clk),
        .mig_wr_clk        (clk),
        .mig_rd_clk        (clk),
        .mig_cmd_en        (mig_cmd_en),
        .mig_cmd_instr     (mig_cmd_instr),
        .mig_cmd_bl        (mig_cmd_bl),
        .mig_cmd_byte_addr (mig_cmd_byte_addr),
        .mig_cmd_empty     (mig_cmd_empty),
        .mig_cmd_full      (mig_cmd_full),
        .mig_wr_en         (mig_wr_en),
        .mig_wr_mask       (mig_wr_mask),
        .mig_wr_data       (mig_wr_data),
        .mig_wr_full       (mig_wr_full),
        .mig_wr_empty      (mig_wr_empty),
        .mig_wr_count      (mig_wr_count),
        .mig_wr_underrun   (mig_wr_underrun),
        .mig_wr_error      (mig_wr_error),
        .mig_rd_en         (mig_rd_en),
        .mig_rd_data       (mig_rd_data),
        .mig_rd_full       (mig_rd_full),
        .mig_rd_empty      (mig_rd_empty),
        .mig_rd_count      (mig_rd_count),
        .mig_rd_overflow   (mig_rd_overflow),
        .mig_rd_error      (mig_rd_error)
    );

    // All stimulus tasks are entered and left at a falling edge.
    task automatic cmd(input logic [2:0] op, input logic [5:0] bl, input logic [29:0] a);
        mig_cmd_en = 1'b1; mig_cmd_instr = op; mig_cmd_bl = bl; mig_cmd_byte_addr = a;
        @(negedge clk);
        mig_cmd_en = 1'b0;
    endtask

    task automatic wpush(input logic [31:0] d, input logic [3:0] m);
        mig_wr_en = 1'b1; mig_wr_data = d; mig_wr_mask = m;
        @(negedge clk);
        mig_wr_en = 1'b0;
    endtask

    task automatic pop(output logic [31:0] d);
        d = mig_rd_data;
        mig_rd_en = 1'b1;
        @(negedge clk);
        mig_rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rd(input logic [6:0] n, output logic ok);
        int i = 0;
        ok = 1'b0;
        while (i < 400 && !ok) begin
            if (mig_rd_count >= n) ok = 1'b1;
            else begin @(negedge clk); i++; end
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA5000000 | (i * 7);
    endfunction

    // {cmd_empty, cmd_full, wr_full, wr_empty, wr_underrun, wr_error, rd_full, rd_empty, rd_overflow, rd_error}
    localparam logic [9:0] RESET_FLAGS = 10'b1001000100;

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        vectors++;
        if ({mig_cmd_empty, mig_cmd_full, mig_wr_full, mig_wr_empty, mig_wr_underrun, mig_wr_error,
             mig_rd_full, mig_rd_empty, mig_rd_overflow, mig_rd_error} !== RESET_FLAGS) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want %b", {mig_cmd_empty, mig_cmd_full, mig_wr_full,
                     mig_wr_empty, mig_wr_underrun, mig_wr_error, mig_rd_full, mig_rd_empty,
                     mig_rd_overflow, mig_rd_error}, RESET_FLAGS);
        end
        vectors++;
        if ({mig_wr_count, mig_rd_count, mig_rd_data} !== 46'h0) begin
            miscompares++;
            $display("FAIL reset_counts_data: wr_count %0d rd_count %0d rd_data %h want 0", mig_wr_count, mig_rd_count, mig_rd_data);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic;
        logic [31:0] d;
        int lat;
        wpush(32'hDEADBEEF, 4'b0000);
        cmd(3'b010, 6'd0, 30'h10);
        idle(5);
        vectors++;
        if (mig_wr_empty !== 1'b1 || mig_wr_underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_write_drain: wr_empty %b underrun %b want 1 0", mig_wr_empty, mig_wr_underrun);
        end
        cmd(3'b001, 6'd0, 30'h10);
        lat = 0;
        while (mig_rd_empty && lat < 50) begin @(negedge clk); lat++; end
        vectors++;
        if (!(lat >= 4 && lat <= 8)) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles want 4..8", lat);
        end
        idle(3);
        vectors++;
        if (mig_rd_data !== 32'hDEADBEEF || mig_rd_count !== 7'd1) begin
            miscompares++;
            $display("FAIL basic_read: data %h count %0d want deadbeef 1", mig_rd_data, mig_rd_count);
        end
        pop(d);
        vectors++;
        if (mig_rd_empty !== 1'b1 || mig_rd_count !== 7'd0) begin
            miscompares++;
            $display("FAIL basic_pop_empty: empty %b count %0d want 1 0", mig_rd_empty, mig_rd_count);
        end
    endtask

    task automatic test_mask;
        logic [31:0] d;
        logic ok;
        wpush(32'hFFFFFFFF, 4'b0000);
        cmd(3'b000, 6'd0, 30'h14);
        wpush(32'h11223344, 4'b0011);
        cmd(3'b010, 6'd0, 30'h14);
        cmd(3'b001, 6'd0, 30'h14);
        wait_rd(7'd1, ok);
        pop(d);
        vectors++;
        if (ok !== 1'b1 || d !== 32'h1122FFFF) begin
            miscompares++;
            $display("FAIL mask_merge: ok %b data %h want 1 1122ffff", ok, d);
        end
        // Bit 12 and byte offset 1 are both outside the word index.
        cmd(3'b011, 6'd0, 30'h1015);
        wait_rd(7'd1, ok);
        pop(d);
        vectors++;
        if (ok !== 1'b1 || d !== 32'h1122FFFF) begin
            miscompares++;
            $display("FAIL addr_alias: ok %b data %h want 1 1122ffff", ok, d);
        end
    endtask

    task automatic test_underrun;
        logic [31:0] d;
        logic [31:0] exp_w [4];
        logic ok;
        exp_w[0] = 32'hA; exp_w[1] = 32'hB; exp_w[2] = 32'h0; exp_w[3] = 32'h0;
        vectors++;
        if (mig_wr_underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL underrun_before: got %b want 0", mig_wr_underrun);
        end
        wpush(32'hA, 4'b0000);
        wpush(32'hB, 4'b0000);
        cmd(3'b000, 6'd3, 30'h40);
        idle(8);
        vectors++;
        if (mig_wr_underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_flag: got %b want 1", mig_wr_underrun);
        end
        cmd(3'b001, 6'd3, 30'h40);
        wait_rd(7'd4, ok);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            pop(d);
            vectors++;
            if (ok !== 1'b1 || d !== exp_w[i]) begin
                miscompares++;
                $display("FAIL underrun_word%0d: ok %b data %h want %h", i, ok, d, exp_w[i]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        logic ok;
        wpush(32'h1, 4'b0000);
        wpush(32'h2, 4'b0000);
        cmd(3'b010, 6'd1, 30'hFFC);
        idle(6);
        cmd(3'b001, 6'd0, 30'hFFC);
        cmd(3'b001, 6'd0, 30'h000);
        wait_rd(7'd2, ok);
        pop(d);
        vectors++;
        if (ok !== 1'b1 || d !== 32'h1) begin
            miscompares++;
            $display("FAIL wrap_word1023: ok %b data %h want 1 00000001", ok, d);
        end
        pop(d);
        vectors++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL wrap_word0: data %h want 00000002", d);
        end
    endtask

    task automatic test_refresh_noop;
        logic [31:0] d;
        logic ok;
        cmd(3'b100, 6'd0, 30'h0);
        cmd(3'b111, 6'd0, 30'h0);
        cmd(3'b001, 6'd0, 30'h14);
        idle(10);
        vectors++;
        if (mig_rd_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL refresh_holdoff: rd_empty %b want 1", mig_rd_empty);
        end
        wait_rd(7'd1, ok);
        pop(d);
        vectors++;
        if (ok !== 1'b1 || d !== 32'h1122FFFF) begin
            miscompares++;
            $display("FAIL refresh_then_read: ok %b data %h want 1 1122ffff", ok, d);
        end
    endtask

    task automatic test_cmd_full;
        int i;
        for (int k = 0; k < 6; k++) cmd(3'b100, 6'd0, 30'h0);
        vectors++;
        if (mig_cmd_full !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_full: got %b want 1", mig_cmd_full);
        end
        i = 0;
        while (!mig_cmd_empty && i < 200) begin @(negedge clk); i++; end
        idle(10);
        vectors++;
        if (mig_cmd_empty !== 1'b1 || mig_cmd_full !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_drain: empty %b full %b want 1 0", mig_cmd_empty, mig_cmd_full);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        for (int i = 0; i < 64; i++) wpush(pat(i), 4'b0000);
        vectors++;
        if (mig_wr_full !== 1'b1 || mig_wr_count !== 7'd64 || mig_wr_error !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_fill: full %b count %0d error %b want 1 64 0", mig_wr_full, mig_wr_count, mig_wr_error);
        end
        wpush(32'hBAD0BAD0, 4'b0000);
        vectors++;
        if (mig_wr_error !== 1'b1 || mig_wr_count !== 7'd64) begin
            miscompares++;
            $display("FAIL wr_error: error %b count %0d want 1 64", mig_wr_error, mig_wr_count);
        end
        cmd(3'b010, 6'd63, 30'h100);
        idle(80);
        cmd(3'b001, 6'd63, 30'h100);
        cmd(3'b011, 6'd63, 30'h100);
        idle(200);
        vectors++;
        if (mig_rd_full !== 1'b1 || mig_rd_count !== 7'd64 || mig_rd_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_overflow: full %b count %0d overflow %b want 1 64 1", mig_rd_full, mig_rd_count, mig_rd_overflow);
        end
        for (int i = 0; i < 64; i++) begin
            pop(d);
            vectors++;
            if (d !== pat(i)) begin
                miscompares++;
                $display("FAIL burst_word%0d: got %h want %h", i, d, pat(i));
            end
        end
        vectors++;
        if (mig_rd_empty !== 1'b1 || mig_rd_error !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_drained: empty %b error %b want 1 0", mig_rd_empty, mig_rd_error);
        end
        pop(d);
        vectors++;
        if (mig_rd_error !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_error: got %b want 1", mig_rd_error);
        end
    endtask

    task automatic test_reset_mid_read;
        logic [31:0] d;
        logic ok;
        cmd(3'b001, 6'd63, 30'h100);
        wait_rd(7'd10, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL midread_start: ok %b want 1", ok);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if ({mig_cmd_empty, mig_cmd_full, mig_wr_full, mig_wr_empty, mig_wr_underrun, mig_wr_error,
             mig_rd_full, mig_rd_empty, mig_rd_overflow, mig_rd_error} !== RESET_FLAGS) begin
            miscompares++;
            $display("FAIL midread_flags: got %b want %b", {mig_cmd_empty, mig_cmd_full, mig_wr_full,
                     mig_wr_empty, mig_wr_underrun, mig_wr_error, mig_rd_full, mig_rd_empty,
                     mig_rd_overflow, mig_rd_error}, RESET_FLAGS);
        end
        vectors++;
        if ({mig_wr_count, mig_rd_count, mig_rd_data} !== 46'h0) begin
            miscompares++;
            $display("FAIL midread_counts: wr_count %0d rd_count %0d rd_data %h want 0", mig_wr_count, mig_rd_count, mig_rd_data);
        end
        idle(20);
        vectors++;
        if (mig_rd_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL midread_aborted: rd_empty %b want 1", mig_rd_empty);
        end
        cmd(3'b001, 6'd0, 30'h14);
        wait_rd(7'd1, ok);
        pop(d);
        vectors++;
        if (ok !== 1'b1 || d !== 32'h1122FFFF) begin
            miscompares++;
            $display("FAIL mem_retained: ok %b data %h want 1 1122ffff", ok, d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mig_cmd_en = 1'b0; mig_cmd_instr = 3'b0; mig_cmd_bl = 6'd0; mig_cmd_byte_addr = 30'h0;
        mig_wr_en = 1'b0; mig_wr_mask = 4'h0; mig_wr_data = 32'h0;
        mig_rd_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_mask();
        test_underrun();
        test_wrap();
        test_refresh_noop();
        test_cmd_full();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mig_port_emu.md
MIG_PORT_EMU -- requirements
Module: mig_port_emu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameters SHALL be (name, default, meaning):
- MEM_AW, 10: word-address width of the backing store (2^MEM_AW x 32 bit).
- RD_LATENCY, 4: cycles from read-command start to the first read-FIFO push.
- CMD_DEPTH, 4: command FIFO depth.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock.
- rst_n, in, 1: synchronous active-low reset.
- mig_cmd_clk, mig_wr_clk, mig_rd_clk, in, 1 each: accepted and unused; the user ties them to clk.
- mig_cmd_en, in, 1: command push.
- mig_cmd_instr, in, 3: command opcode.
- mig_cmd_bl, in, 6: burst length minus 1.
- mig_cmd_byte_addr, in, 30: byte address.
- mig_cmd_empty, mig_cmd_full, out, 1 each: command FIFO status.
- mig_wr_en, in, 1: write-data push.
- mig_wr_mask, in, 4: byte mask (1 = byte not written).
- mig_wr_data, in, 32: write data.
- mig_wr_full, mig_wr_empty, out, 1 each: write FIFO status.
- mig_wr_count, out, 7: write FIFO occupancy, 0..64.
- mig_wr_underrun, mig_wr_error, out, 1 each: sticky error flags.
- mig_rd_en, in, 1: read-data pop.
- mig_rd_data, out, 32: head of the read FIFO.
- mig_rd_full, mig_rd_empty, out, 1 each: read FIFO status.
- mig_rd_count, out, 7: read FIFO occupancy, 0..64.
- mig_rd_overflow, mig_rd_error, out, 1 each: sticky error flags.

Function
REQ-004 Command FIFO: an entry is pushed when mig_cmd_en=1 and mig_cmd_full=0; mig_cmd_en while full SHALL be dropped silently.
REQ-005 Write FIFO: depth 64, data and mask together. mig_wr_en while full SHALL drop the word and set mig_wr_error.
REQ-006 Read FIFO: depth 64, first-word-fall-through. mig_rd_data SHALL be valid whenever mig_rd_empty=0. mig_rd_en with empty=0 pops the head. mig_rd_en with empty=1 is ignored and sets mig_rd_error.
REQ-007 Full and empty flags SHALL come from registered occupancy. A push while full is dropped even if a pop occurs in the same cycle. A push and a pop on a non-full FIFO in the same cycle SHALL leave the count unchanged.
REQ-008 Opcodes SHALL decode as follows: 000 and 010 write; 001 and 011 read; 100 refresh; any other opcode is consumed as a 1-cycle no-op.
REQ-009 Word index SHALL be byte_addr[MEM_AW+1:2]; bits [1:0] and bits above MEM_AW+1 SHALL be ignored (aliasing).
REQ-010 Burst word k (k = 0..bl) SHALL target (index+k) mod 2^MEM_AW, i.e. bursts wrap around.
REQ-011 Executor FSM states SHALL be IDLE, WRITE, RD_WAIT, READ, REFRESH:
- IDLE: pops the command-FIFO head when non-empty and moves to the state for its opcode.
- WRITE: one word per cycle for bl+1 cycles. Each word pops the write FIFO and writes the unmasked bytes. If the FIFO is empty when a word is needed, zero is written with all bytes enabled and mig_wr_underrun is set.
- RD_WAIT: RD_LATENCY cycles, then READ.
- READ: pushes one memory word per cycle for bl+1 cycles. A push while the read FIFO is full drops the word and sets mig_rd_overflow.
- REFRESH: 8 cycles, then IDLE.
- All burst states return to IDLE after their last word; IDLE may pop the next command in that same cycle.
REQ-012 A memory write followed by a read of the same word in the next command SHALL return the new data (no stale-read hazard).
REQ-013 Error flags SHALL stay set until reset.

Reset
REQ-014 While rst_n=0 at a clock edge, the block SHALL:
- empty all FIFOs;
- drive empty flags to 1, full flags to 0, counts to 0, error flags to 0 and mig_rd_data to 0;
- return the FSM to IDLE.
REQ-015 Reset SHALL abort any burst in progress. Memory contents SHALL NOT be reset.

Structure
REQ-016 Shared package mig_port_pkg SHALL hold the opcode constants, the FSM state encoding and the FIFO depth constant.
REQ-017 One sub-module, sync_fifo, SHALL provide a parameterised width/depth first-word-fall-through FIFO. It SHALL be instantiated three times: command, write and read.

Verification
REQ-018 Push 0xDEADBEEF with mask 0; write cmd 010, bl=0, addr 0x10; then read cmd 001, bl=0, addr 0x10 -> rd_empty falls RD_LATENCY+ cycles after read start, rd_data=0xDEADBEEF, rd_count=1.
REQ-019 Write 0xFFFFFFFF to word 5; push 0x11223344 with mask 4'b0011 to word 5; read word 5 -> 0x1122FFFF.
REQ-020 Write cmd bl=3 with only 2 words pushed (0xA, 0xB) -> mig_wr_underrun=1; read bl=3 returns 0xA, 0xB, 0, 0.
REQ-021 Two read cmds with bl=63, no pops -> rd_full=1, rd_count=64, mig_rd_overflow=1; first 64 popped words equal the first burst.
REQ-022 Write bl=1 at byte addr 0xFFC (MEM_AW=10) with 0x1, 0x2 -> word 1023=0x1, word 0=0x2.
REQ-023 rst_n=0 for one cycle mid-READ -> next cycle rd_empty=1, wr_empty=1, cmd_empty=1, counts 0, all error flags 0.
